// File: rtl/risc_sequencer.sv
// Instruction-cycle sequencer: fetch handshake, execute stall, halt/resume,
// fetch-timeout fault and retired-instruction counter.
module risc_sequencer #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             run_en,
   input  logic             imem_ack,
   input  logic             exec_stall,
   input  logic             halt_instr,
   input  logic             resume,
   input  logic             clear_fault,
   output logic [2:0]       Current_State,
   output logic             imem_req,
   output logic             halted,
   output logic             fault,
   output logic [CNT_W-1:0] instr_count
);

   localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_RESET     = 3'b000,
      S_FETCH     = 3'b001,
      S_READ_OPS  = 3'b010,
      S_EXECUTE   = 3'b011,
      S_WRITEBACK = 3'b100,
      S_HALT      = 3'b101,
      S_FAULT     = 3'b110
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [WAIT_W-1:0]   wait_cnt;
   logic                timeout_c;

   assign timeout_c     = (wait_cnt == WAIT_W'(TIMEOUT - 1));
   assign Current_State = state;

   // State register; status outputs are registered from the next state so
   // they always match Current_State.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_RESET;
         imem_req <= 1'b0;
         halted   <= 1'b0;
         fault    <= 1'b0;
      end else begin
         state    <= state_next;
         imem_req <= (state_next == S_FETCH);
         halted   <= (state_next == S_HALT);
         fault    <= (state_next == S_FAULT);
      end
   end

   // Next-state decode
   always_comb begin
      state_next = S_RESET;
      case (state)
         S_RESET:     state_next = run_en ? S_FETCH : S_RESET;
         S_FETCH: begin
            if (imem_ack)       state_next = S_READ_OPS;
            else if (timeout_c) state_next = S_FAULT;
            else                state_next = S_FETCH;
         end
         S_READ_OPS:  state_next = S_EXECUTE;
         S_EXECUTE:   state_next = exec_stall ? S_EXECUTE : S_WRITEBACK;
         S_WRITEBACK: begin
            if (halt_instr)  state_next = S_HALT;
            else if (run_en) state_next = S_FETCH;
            else             state_next = S_RESET;
         end
         S_HALT:      state_next = resume ? S_FETCH : S_HALT;
         S_FAULT:     state_next = clear_fault ? S_RESET : S_FAULT;
         default:     state_next = S_RESET;
      endcase
   end

   // Fetch wait counter: counts cycles spent in FETCH, cleared on any exit
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         wait_cnt <= '0;
      else if (state == S_FETCH && !imem_ack && !timeout_c)
         wait_cnt <= wait_cnt + WAIT_W'(1);
      else
         wait_cnt <= '0;
   end

   // Retired-instruction counter, bumps on the WRITEBACK exit edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         instr_count <= '0;
      else if (state == S_WRITEBACK)
         instr_count <= instr_count + CNT_W'(1);
   end

endmodule
